demux4_reg: RTL and testbench
=============================

DEMUX4_REG -- requirements
Module: demux4_reg

Interface
REQ-001 Parameter WIDTH, default 16, data width of input and each output channel.
REQ-002 Parameter NCH, default 4, number of output channels; fixed at 4 in this revision.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_data  input  WIDTH  data word to distribute.
REQ-006 i_valid  input  1  i_data is valid this cycle; word accepted on any edge with i_valid=1.
REQ-007 i_ctrl  input  2  target channel in manual mode.
REQ-008 i_auto  input  1  1 = round-robin target from internal pointer; 0 = target from i_ctrl.
REQ-009 o_data_0..o_data_3  output  WIDTH each  per-channel hold registers.
REQ-010 o_valid  output  4  one-hot, one-cycle strobe marking the channel just written.
REQ-011 o_ptr  output  2  current round-robin pointer.
REQ-012 o_frame  output  1  one-cycle pulse when an auto-mode write lands on channel 3.

Function
REQ-013 Target channel sel SHALL be o_ptr when i_auto=1, else i_ctrl.
REQ-014 On an edge with i_valid=1, o_data_<sel> SHALL load i_data; all other channels SHALL hold.
REQ-015 On an edge with i_valid=0, all o_data_n SHALL hold.
REQ-016 Latency SHALL be one cycle: word visible on o_data_<sel> after the accepting edge.
REQ-017 o_valid SHALL be registered: bit sel = 1 for exactly the cycle after acceptance, else 0; at most one bit set.
REQ-018 Back-to-back i_valid SHALL be accepted every cycle with no bubble; o_valid follows each word.
REQ-019 o_ptr SHALL increment by 1 modulo 4 on each accepted word when i_auto=1; wraps 3->0.
REQ-020 o_ptr SHALL hold when i_auto=0 or i_valid=0.
REQ-021 Mode switch auto->manual SHALL not modify o_ptr; manual->auto SHALL resume from held o_ptr.
REQ-022 i_auto and i_ctrl SHALL be sampled on the same edge as i_data; changes take effect on that word.
REQ-023 o_frame SHALL be 1 for the cycle after an accepted auto-mode word with sel=3, else 0; manual writes to channel 3 SHALL not assert it.
REQ-024 No backpressure: block SHALL always accept; no data loss or reordering.

Reset
REQ-025 While i_rst_n=0: o_data_0..3 = 0, o_valid = 4'b0000, o_ptr = 2'b00, o_frame = 0, independent of i_clk.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight word; first word after release SHALL target channel 0 in auto mode.
REQ-027 First accepting edge SHALL be the first rising edge with i_rst_n=1.

Structure
REQ-028 Shared package SHALL hold DATA_W=16, NCH=4, PTR_W=2 constants.
REQ-029 One sub-module demux4_chan_reg (WIDTH-bit register with load enable, async active-low clear), instantiated four times.
REQ-030 Pointer, strobe and frame logic SHALL reside in top level; target 120-400 lines total.

Verification
REQ-031 Reset then i_auto=0, i_valid=1, i_ctrl=2'b10, i_data=16'hff00 -> next cycle o_data_2=16'hff00, o_valid=4'b0100, other channels 0.
REQ-032 i_auto=1, four consecutive valid words 16'h0000,16'h00ff,16'hff00,16'hffff -> o_data_0..3 hold them in order, o_ptr 0->1->2->3->0, o_frame pulses once after fourth.
REQ-033 i_auto=1, i_valid toggled 1,0,1 with 16'h1111,xx,16'h2222 -> o_data_0=16'h1111, o_data_1=16'h2222, o_ptr holds during gap, o_valid 0 in gap cycle.
REQ-034 Two auto words, switch i_auto=0 with i_ctrl=2'b11 word 16'habcd, switch back -> o_data_3=16'habcd, o_frame stays 0, next auto word lands on channel 2.
REQ-035 Assert i_rst_n=0 between clock edges after three auto words -> all outputs 0 immediately; next auto word after release lands on channel 0.
REQ-036 i_valid=0 for 8 cycles with varying i_data/i_ctrl -> all o_data_n unchanged, o_valid=0.

Source files
------------

// File: rtl/demux4_reg_pkg.sv
// Shared constants and helpers for the four-channel registered demultiplexer.
package demux4_reg_pkg;

  localparam int DATA_W = 16;
  localparam int NCH    = 4;
  localparam int PTR_W  = 2;

  typedef logic [PTR_W-1:0] ptr_t;

  // One-hot channel decode of a channel index.
  function automatic logic [NCH-1:0] chan_onehot(input ptr_t sel);
    chan_onehot      = '0;
    chan_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/demux4_chan_reg.sv
// Single output channel: WIDTH-bit hold register with load enable and async clear.
module demux4_chan_reg #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // NOTE: the data register is cleared by reset because every output must
  // read zero while reset is held; non-blocking assignment keeps the update
  // ordered correctly against other clocked processes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= '0;
    end else if (i_load) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer with manual or round-robin channel selection.
module demux4_reg #(
  parameter int WIDTH = demux4_reg_pkg::DATA_W,
  parameter int NCH   = demux4_reg_pkg::NCH
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [WIDTH-1:0]                  i_data,
  input  logic                              i_valid,
  input  logic [demux4_reg_pkg::PTR_W-1:0]  i_ctrl,
  input  logic                              i_auto,
  output logic [WIDTH-1:0]                  o_data_0,
  output logic [WIDTH-1:0]                  o_data_1,
  output logic [WIDTH-1:0]                  o_data_2,
  output logic [WIDTH-1:0]                  o_data_3,
  output logic [NCH-1:0]                    o_valid,
  output logic [demux4_reg_pkg::PTR_W-1:0]  o_ptr,
  output logic                              o_frame
);

  import demux4_reg_pkg::*;

  ptr_t             sel;
  logic [NCH-1:0]   load;
  logic [WIDTH-1:0] data_q [NCH];

  // NOTE: give every always_comb output a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    load = '0;
    sel  = i_auto ? o_ptr : i_ctrl;
    if (i_valid) begin
      load = chan_onehot(sel);
    end
  end

  // Strobe and frame are registered so they line up with the data they mark.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ptr   <= '0;
      o_valid <= '0;
      o_frame <= 1'b0;
    end else begin
      o_valid <= load;
      o_frame <= i_valid && i_auto && (sel == ptr_t'(NCH - 1));
      if (i_valid && i_auto) begin
        o_ptr <= o_ptr + ptr_t'(1);
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    demux4_chan_reg #(.WIDTH(WIDTH)) u_chan (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (load[g]),
      .i_d     (i_data),
      .o_q     (data_q[g])
    );
  end

  assign o_data_0 = data_q[0];
  assign o_data_1 = data_q[1];
  assign o_data_2 = data_q[2];
  assign o_data_3 = data_q[3];

endmodule

// File: tb/tb_demux4_reg.sv
// Self-checking bench for demux4_reg: a table of directed vectors plus reset/mode sequences.
module tb_demux4_reg;

  logic        clk;
  logic        rst_n;
  logic [15:0] data;
  logic        valid;
  logic [1:0]  ctrl;
  logic        auto_m;
  logic [15:0] d0, d1, d2, d3;
  logic [3:0]  vld;
  logic [1:0]  ptr;
  logic        frame;

  int pass_cnt  = 0;
  int total_cnt = 0;

  demux4_reg dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_data   (data),
    .i_valid  (valid),
    .i_ctrl   (ctrl),
    .i_auto   (auto_m),
    .o_data_0 (d0),
    .o_data_1 (d1),
    .o_data_2 (d2),
    .o_data_3 (d3),
    .o_valid  (vld),
    .o_ptr    (ptr),
    .o_frame  (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        is_auto;
    logic [1:0]  ctrl;
    logic [15:0] data;
    logic [15:0] e_d0;
    logic [15:0] e_d1;
    logic [15:0] e_d2;
    logic [15:0] e_d3;
    logic [3:0]  e_vld;
    logic [1:0]  e_ptr;
    logic        e_frame;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3,
                           input logic [3:0] ev, input logic [1:0] ep, input logic ef);
    check({tag, ".d0"}, 32'(d0), 32'(e0));
    check({tag, ".d1"}, 32'(d1), 32'(e1));
    check({tag, ".d2"}, 32'(d2), 32'(e2));
    check({tag, ".d3"}, 32'(d3), 32'(e3));
    check({tag, ".valid"}, 32'(vld), 32'(ev));
    check({tag, ".ptr"}, 32'(ptr), 32'(ep));
    check({tag, ".frame"}, 32'(frame), 32'(ef));
  endtask

  // Drive inputs away from the edge, take one rising edge, sample 1 time unit later.
  task automatic step(input logic v, input logic a, input logic [1:0] c, input logic [15:0] d);
    valid  = v;
    auto_m = a;
    ctrl   = c;
    data   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // valid auto ctrl data      | d0       d1       d2       d3       vld      ptr   frame
    vecs[0]  = '{1'b1, 1'b0, 2'd2, 16'hff00, 16'h0000, 16'h0000, 16'hff00, 16'h0000, 4'b0100, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 2'd3, 16'h0000, 16'h0000, 16'h0000, 16'hff00, 16'h0000, 4'b0001, 2'd1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 2'd0, 16'h00ff, 16'h0000, 16'h00ff, 16'hff00, 16'h0000, 4'b0010, 2'd2, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 2'd1, 16'hff00, 16'h0000, 16'h00ff, 16'hff00, 16'h0000, 4'b0100, 2'd3, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 2'd0, 16'hffff, 16'h0000, 16'h00ff, 16'hff00, 16'hffff, 4'b1000, 2'd0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 2'd2, 16'h1111, 16'h1111, 16'h00ff, 16'hff00, 16'hffff, 4'b0001, 2'd1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'd3, 16'hdead, 16'h1111, 16'h00ff, 16'hff00, 16'hffff, 4'b0000, 2'd1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 2'd0, 16'h2222, 16'h1111, 16'h2222, 16'hff00, 16'hffff, 4'b0010, 2'd2, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'd3, 16'habcd, 16'h1111, 16'h2222, 16'hff00, 16'habcd, 4'b1000, 2'd2, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 16'h0001, 16'h1111, 16'h2222, 16'hff00, 16'habcd, 4'b0000, 2'd2, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'd1, 16'h0202, 16'h1111, 16'h2222, 16'hff00, 16'habcd, 4'b0000, 2'd2, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 2'd2, 16'h3030, 16'h1111, 16'h2222, 16'hff00, 16'habcd, 4'b0000, 2'd2, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 2'd3, 16'h4444, 16'h1111, 16'h2222, 16'hff00, 16'habcd, 4'b0000, 2'd2, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 2'd3, 16'hffff, 16'h1111, 16'h2222, 16'hff00, 16'habcd, 4'b0000, 2'd2, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 2'd2, 16'h0000, 16'h1111, 16'h2222, 16'hff00, 16'habcd, 4'b0000, 2'd2, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 2'd1, 16'h8001, 16'h1111, 16'h2222, 16'hff00, 16'habcd, 4'b0000, 2'd2, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 2'd0, 16'h7ffe, 16'h1111, 16'h2222, 16'hff00, 16'habcd, 4'b0000, 2'd2, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 2'd0, 16'h5a5a, 16'h1111, 16'h2222, 16'h5a5a, 16'habcd, 4'b0100, 2'd3, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 2'd0, 16'h0f0f, 16'h0f0f, 16'h2222, 16'h5a5a, 16'habcd, 4'b0001, 2'd3, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 2'd1, 16'h3c3c, 16'h0f0f, 16'h2222, 16'h5a5a, 16'h3c3c, 4'b1000, 2'd0, 1'b1};

    rst_n  = 1'b0;
    valid  = 1'b0;
    auto_m = 1'b0;
    ctrl   = 2'd0;
    data   = 16'h0000;
    #2;
    check_all("reset_hold", 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 2'd0, 1'b0);
    // Accepting edge while still in reset must not load anything.
    valid = 1'b1;
    data  = 16'hbeef;
    @(posedge clk);
    #1;
    check_all("reset_edge", 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 2'd0, 1'b0);
    valid = 1'b0;
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].valid, vecs[i].is_auto, vecs[i].ctrl, vecs[i].data);
      check_all($sformatf("vec%0d", i), vecs[i].e_d0, vecs[i].e_d1, vecs[i].e_d2, vecs[i].e_d3,
                vecs[i].e_vld, vecs[i].e_ptr, vecs[i].e_frame);
    end

    // Two auto words, a manual write to channel 3, then auto resumes on channel 2.
    do_reset();
    step(1'b1, 1'b1, 2'd0, 16'h1234);
    step(1'b1, 1'b1, 2'd0, 16'h5678);
    step(1'b1, 1'b0, 2'd3, 16'habcd);
    check_all("mode_manual", 16'h1234, 16'h5678, 16'h0000, 16'habcd, 4'b1000, 2'd2, 1'b0);
    step(1'b1, 1'b1, 2'd3, 16'h9999);
    check_all("mode_resume", 16'h1234, 16'h5678, 16'h9999, 16'habcd, 4'b0100, 2'd3, 1'b0);

    // Reset asserted between edges after three auto words, with a word in flight.
    do_reset();
    step(1'b1, 1'b1, 2'd0, 16'haaaa);
    step(1'b1, 1'b1, 2'd0, 16'hbbbb);
    step(1'b1, 1'b1, 2'd0, 16'hcccc);
    check_all("pre_rst", 16'haaaa, 16'hbbbb, 16'hcccc, 16'h0000, 4'b0100, 2'd3, 1'b0);
    valid = 1'b1;
    data  = 16'hdddd;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_inflight", 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 2'd0, 1'b0);
    #2;
    rst_n = 1'b1;
    step(1'b1, 1'b1, 2'd2, 16'heeee);
    check_all("post_rst", 16'heeee, 16'h0, 16'h0, 16'h0, 4'b0001, 2'd1, 1'b0);
    step(1'b0, 1'b1, 2'd0, 16'h0000);
    check_all("strobe_drop", 16'heeee, 16'h0, 16'h0, 16'h0, 4'b0000, 2'd1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
